// File: rtl/apb_cfg_master.sv
// APB4 initiator: turns one valid/ready command into one SETUP/ACCESS transfer
// with wait-state support and an optional timeout, returning one response pulse.
module apb_cfg_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_tmo,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_waitCnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic                r_rspValid;
  logic [DATA_W-1:0]   r_rspRdata;
  logic                r_rspErr;
  logic                r_rspTmo;
  logic                w_timeoutHit;

  // Abort on the ACCESS cycle that would take the wait count up to TIMEOUT.
  assign w_timeoutHit = (TIMEOUT > 0) && (r_waitCnt == CNT_W'(TIMEOUT - 1));

  // Gated by rst_n so cmd_ready drops with the reset itself, not a clock later.
  assign cmd_ready = rst_n & (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_waitCnt  <= '0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
      r_rspTmo   <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_pwrite  <= cmd_write;
            r_paddr   <= cmd_addr;
            r_pwdata  <= cmd_wdata;
            r_pstrb   <= cmd_write ? cmd_strb : '0;
            r_psel    <= 1'b1;
            r_waitCnt <= '0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
            r_rspErr   <= pslverr;
            r_rspTmo   <= 1'b0;
            r_rspRdata <= r_pwrite ? '0 : prdata;
            r_state    <= IDLE;
          end else if (w_timeoutHit) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
            r_rspErr   <= 1'b1;
            r_rspTmo   <= 1'b1;
            r_rspRdata <= '0;
            r_state    <= IDLE;
          end else if (r_waitCnt != '1) begin
            // Saturates rather than wraps when the timeout is disabled.
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;
  assign rsp_tmo   = r_rspTmo;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Self-checking bench for apb_cfg_master: cycle vectors for single transfers,
// plus hand-written sequences for back-to-back, timeout and mid-transfer reset.
module tb_apb_cfg_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic        memMode;
  logic        vecPready;
  logic [31:0] vecPrdata;
  logic [31:0] mem [16];

  int testsRun;
  int failCount;

  typedef struct {
    logic        valid;
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        eReady;
    logic        ePsel;
    logic        ePen;
    logic        eWrite;
    logic [11:0] eAddr;
    logic [31:0] eWdata;
    logic [3:0]  eStrb;
    logic        eRspV;
    logic [31:0] eRdata;
    logic        eErr;
    logic        eTmo;
  } vec_t;

  vec_t vecs [14];

  apb_cfg_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_tmo   (rsp_tmo),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completer is either driven per-vector or a zero-wait memory model.
  assign pready = memMode ? 1'b1 : vecPready;
  assign prdata = memMode ? mem[paddr[5:2]] : vecPrdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cmd_valid = v.valid;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    vecPready = v.pready;
    vecPrdata = v.prdata;
    pslverr   = v.pslverr;
  endtask

  task automatic checkVector(input vec_t v, input int i);
    checkOutput($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(v.eReady));
    checkOutput($sformatf("v%0d_psel", i),      32'(psel),      32'(v.ePsel));
    checkOutput($sformatf("v%0d_penable", i),   32'(penable),   32'(v.ePen));
    checkOutput($sformatf("v%0d_pwrite", i),    32'(pwrite),    32'(v.eWrite));
    checkOutput($sformatf("v%0d_paddr", i),     32'(paddr),     32'(v.eAddr));
    checkOutput($sformatf("v%0d_pwdata", i),    pwdata,         v.eWdata);
    checkOutput($sformatf("v%0d_pstrb", i),     32'(pstrb),     32'(v.eStrb));
    checkOutput($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(v.eRspV));
    checkOutput($sformatf("v%0d_rsp_rdata", i), rsp_rdata,      v.eRdata);
    checkOutput($sformatf("v%0d_rsp_err", i),   32'(rsp_err),   32'(v.eErr));
    checkOutput($sformatf("v%0d_rsp_tmo", i),   32'(rsp_tmo),   32'(v.eTmo));
  endtask

  logic [11:0] bAddr  [4];
  logic [31:0] bWdata [4];
  logic        bWrite [4];
  logic [31:0] bRdata [4];

  task automatic loadCmd(input int k);
    cmd_write = bWrite[k];
    cmd_addr  = bAddr[k];
    cmd_wdata = bWdata[k];
    cmd_strb  = 4'hF;
  endtask

  initial begin
    int idx;
    int rspIdx;
    int accCnt;
    logic seen;
    logic accepted;
    logic prevPsel;
    int acc [4];

    testsRun  = 0;
    failCount = 0;
    memMode   = 1'b0;
    vecPready = 1'b0;
    vecPrdata = 32'h0;
    pslverr   = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hCAFE_0000;
    for (int i = 0; i < 4; i++) acc[i] = 0;

    // valid write addr wdata strb pready prdata pslverr | ready psel pen write addr wdata strb rspv rdata err tmo
    vecs[0]  = '{1'b1, 1'b1, 12'h00C, 32'h0000_1234, 4'hF, 1'b1, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b1, 12'h00C, 32'h0000_1234, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 12'h0FF, 32'h0000_9999, 4'h5, 1'b1, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b1, 1'b1, 12'h00C, 32'h0000_1234, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 12'h0FF, 32'h0000_9999, 4'h5, 1'b1, 32'hDEAD_BEEF, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b1, 12'h00C, 32'h0000_1234, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b1, 12'h00C, 32'h0000_1234, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 12'h010, 32'hAAAA_5555, 4'hF, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'hAAAA_5555, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    for (int i = 5; i < 9; i++)
      vecs[i] = '{1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0,
                  1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 32'hAAAA_5555, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 32'hAAAA_5555, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 12'h020, 32'h0000_0055, 4'h3, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b1, 12'h020, 32'h0000_0055, 4'h3, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b1, 1'b1, 12'h020, 32'h0000_0055, 4'h3, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 32'h0000_1111, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b1, 12'h020, 32'h0000_0055, 4'h3, 1'b1, 32'h0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b1, 12'h020, 32'h0000_0055, 4'h3, 1'b0, 32'h0, 1'b1, 1'b0};

    bWrite[0] = 1'b1; bAddr[0] = 12'h014; bWdata[0] = 32'h1357_9BDF; bRdata[0] = 32'h0;
    bWrite[1] = 1'b0; bAddr[1] = 12'h014; bWdata[1] = 32'h0;         bRdata[1] = 32'h1357_9BDF;
    bWrite[2] = 1'b1; bAddr[2] = 12'h018; bWdata[2] = 32'h2468_ACE0; bRdata[2] = 32'h0;
    bWrite[3] = 1'b0; bAddr[3] = 12'h000; bWdata[3] = 32'h0;         bRdata[3] = 32'hCAFE_0000;

    // Reset state, with a command offered that must be ignored.
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h0AB;
    cmd_wdata = 32'h1111_2222;
    cmd_strb  = 4'hF;
    tick();
    tick();
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    checkOutput("rst_psel",      32'(psel),      32'h0);
    checkOutput("rst_penable",   32'(penable),   32'h0);
    checkOutput("rst_pwrite",    32'(pwrite),    32'h0);
    checkOutput("rst_paddr",     32'(paddr),     32'h0);
    checkOutput("rst_pwdata",    pwdata,         32'h0);
    checkOutput("rst_pstrb",     32'(pstrb),     32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata,      32'h0);
    checkOutput("rst_rsp_err",   32'(rsp_err),   32'h0);
    checkOutput("rst_rsp_tmo",   32'(rsp_tmo),   32'h0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    checkOutput("rel_cmd_ready", 32'(cmd_ready), 32'h1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkVector(vecs[i], i);
    end

    // Back-to-back commands against the memory completer.
    memMode   = 1'b1;
    pslverr   = 1'b0;
    idx       = 0;
    rspIdx    = 0;
    prevPsel  = psel;
    loadCmd(0);
    cmd_valid = 1'b1;
    for (int c = 0; c < 60 && rspIdx < 4; c++) begin
      accepted = 1'b0;
      if (idx < 4 && cmd_ready) begin
        acc[idx] = c;
        accepted = 1'b1;
      end
      if (psel && penable && pwrite) mem[paddr[5:2]] = pwdata;
      tick();
      if (psel && !prevPsel) checkOutput("b2b_setup_penable", 32'(penable), 32'h0);
      prevPsel = psel;
      if (rsp_valid && rspIdx < 4) begin
        checkOutput($sformatf("b2b_rdata%0d", rspIdx), rsp_rdata, bRdata[rspIdx]);
        checkOutput($sformatf("b2b_err%0d", rspIdx), 32'(rsp_err), 32'h0);
        rspIdx++;
      end
      if (accepted) begin
        idx++;
        if (idx < 4) loadCmd(idx);
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checkOutput("b2b_rsp_count", 32'(rspIdx), 32'd4);
    for (int k = 1; k < 4; k++)
      checkOutput($sformatf("b2b_spacing%0d", k), 32'(acc[k] - acc[k-1]), 32'd3);
    checkOutput("b2b_mem18", mem[6], 32'h2468_ACE0);
    memMode = 1'b0;

    // Timeout: completer never ready.
    vecPready = 1'b0;
    vecPrdata = 32'h1234_5678;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 12'h030;
    tick();
    cmd_valid = 1'b0;
    checkOutput("tmo_setup_psel", 32'(psel), 32'h1);
    accCnt = 0;
    seen   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (penable) accCnt++;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("tmo_rsp_seen",  32'(seen),      32'h1);
    checkOutput("tmo_access_len", 32'(accCnt),   32'd16);
    checkOutput("tmo_psel",      32'(psel),      32'h0);
    checkOutput("tmo_rsp_err",   32'(rsp_err),   32'h1);
    checkOutput("tmo_rsp_tmo",   32'(rsp_tmo),   32'h1);
    checkOutput("tmo_rsp_rdata", rsp_rdata,      32'h0);
    checkOutput("tmo_cmd_ready", 32'(cmd_ready), 32'h1);

    // Next command after a timeout completes normally.
    vecPready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h040;
    cmd_wdata = 32'h0000_ABCD;
    cmd_strb  = 4'hF;
    tick();
    cmd_valid = 1'b0;
    checkOutput("post_tmo_psel",  32'(psel),  32'h1);
    checkOutput("post_tmo_paddr", 32'(paddr), 32'h040);
    tick();
    tick();
    checkOutput("post_tmo_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("post_tmo_rsp_err",   32'(rsp_err),   32'h0);
    checkOutput("post_tmo_rsp_tmo",   32'(rsp_tmo),   32'h0);

    // Asynchronous reset in the middle of ACCESS.
    vecPready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h0FC;
    cmd_wdata = 32'h0000_0077;
    cmd_strb  = 4'hC;
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("rstacc_pre_penable", 32'(penable), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstacc_psel",      32'(psel),      32'h0);
    checkOutput("rstacc_penable",   32'(penable),   32'h0);
    checkOutput("rstacc_pwrite",    32'(pwrite),    32'h0);
    checkOutput("rstacc_paddr",     32'(paddr),     32'h0);
    checkOutput("rstacc_pstrb",     32'(pstrb),     32'h0);
    checkOutput("rstacc_cmd_ready", 32'(cmd_ready), 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    checkOutput("rstacc_rel_ready", 32'(cmd_ready), 32'h1);
    vecPready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("rstacc_no_rsp%0d", c), 32'(rsp_valid), 32'h0);
      checkOutput($sformatf("rstacc_no_psel%0d", c), 32'(psel), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
APB initiator that drives the timer register slave, or any APB4 completer, from a simple valid/ready command port. It turns one accepted command into one APB4 transfer: a SETUP phase, then an ACCESS phase with wait-state support and a timeout. It returns one response pulse per command. It sits between the test/CPU-side command source and the timer's APB slave port.

Parameters:
ADDR_W, 12, width of cmd_addr and paddr
DATA_W, 32, width of write/read data; strobe width is DATA_W/8
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  byte address
cmd_wdata  input  DATA_W  write data
cmd_strb  input  DATA_W/8  byte strobes (writes only)
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_W  read data (0 for writes, 0 on timeout)
rsp_err  output  1  pslverr sampled, or timeout
rsp_tmo  output  1  transfer aborted by timeout
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
pstrb  output  DATA_W/8  APB strobes
prdata  input  DATA_W  completer read data
pready  input  1  completer ready
pslverr  input  1  completer error

Behaviour:
- Clock/reset: one clock (clk); reset rst_n is asynchronous, active-low. Reset forces state IDLE, wait counter 0 and every output to 0, including cmd_ready.
- cmd_ready deasserts in the same reset assertion; it is 1 in the first cycle after reset release.
- All outputs come straight from flops, except cmd_ready, which is decoded from state.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid: latch pwrite=cmd_write, paddr=cmd_addr, pwdata=cmd_wdata.
  - pstrb=cmd_strb for a write, 0 for a read (APB4 rule).
  - Next state SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready=0. Next state ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite, pwdata and pstrb hold stable from SETUP until the transfer ends.
  - pready=1: complete. Next cycle: state IDLE, psel=0, penable=0, rsp_valid=1 for one cycle.
  - On completion: rsp_err=pslverr, rsp_tmo=0, rsp_rdata=prdata for a read, 0 for a write.
  - pready=0: increment the wait counter.
  - Wait counter reaches TIMEOUT (TIMEOUT>0): abort. Next cycle: IDLE, psel/penable=0, rsp_valid=1, rsp_err=1, rsp_tmo=1, rsp_rdata=0.
  - A pready arriving in the abort cycle is ignored.
- Wait counter: clears on entering SETUP. Its width is ceil(log2(TIMEOUT+1)), minimum 1 bit. It saturates when TIMEOUT=0.
- Latency:
  - Zero-wait transfer: accept cycle T; SETUP at T+1; ACCESS at T+2; rsp_valid at T+3.
  - N wait states add N cycles.
- Back-to-back: cmd_ready returns in the same cycle rsp_valid pulses. The peak rate is one command every 3 cycles.
- rsp_valid has no backpressure; the consumer must accept it.
- Between responses, rsp_* hold their last values. Only rsp_valid returns to 0.
- paddr, pwdata, pwrite and pstrb keep their last values in IDLE. Only psel and penable drop.
- Command inputs are ignored outside IDLE.
- Asynchronous reset during SETUP or ACCESS aborts the transfer immediately: psel/penable=0 and no rsp_valid.
- Issuing a misaligned address is the caller's responsibility; the block passes it through unchanged.

Test Plan:
- Write addr 0x00C, data 0x0000_1234, strb 0xF, pready tied 1 -> SETUP then ACCESS with paddr=0x00C, pwdata=0x1234, pstrb=0xF. rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read addr 0x010, completer holds pready=0 for 3 cycles, then returns prdata=0xFFFF_FFFF -> penable high for 4 cycles. Address stable throughout, pstrb=0. rsp_rdata=0xFFFF_FFFF at accept+6.
- Write with pslverr=1 in the pready cycle -> rsp_valid=1, rsp_err=1, rsp_tmo=0.
- TIMEOUT=16, pready stuck 0 -> ACCESS lasts 16 cycles, then psel=0. rsp_valid with rsp_err=1, rsp_tmo=1, rsp_rdata=0. The next command is accepted normally.
- cmd_valid held high with 4 queued commands (write 0x014, read 0x014, write 0x018, read 0x000) and zero wait -> one psel transfer every 3 cycles. psel never goes high while penable is stuck high, and the reads return the values written.
- rst_n pulsed low during ACCESS -> psel, penable, pwrite, paddr and pstrb are 0 within the reset assertion with no clock edge. No rsp_valid; cmd_ready=1 in the first cycle after release.
